// File: rtl/iic_cfg_seq.sv
// iic_cfg_seq: walks a {reg_addr, data} table after reset or on cfg_start. Each entry is
// issued as an I2C write through iic_driver and, if VERIFY, read back and compared.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   cfg_start                 re-run request, honoured only when finished
//   cfg_index / cfg_entry     table lookup; entry is valid the cycle after the index changes
//   iic_exe, iic_rw_ctrl,     transaction request to iic_driver (1 = write)
//   bit_ctrl, iic_addr,
//   iic_data_in
//   iic_data_out, iic_ack,    transaction result; iic_ack = 1 means NACK; only the
//   iic_done                  rising edge of iic_done completes a transaction
//   cfg_busy, cfg_done,       sequence status
//   cfg_err, err_cnt          sticky failure flag and saturating failed-entry count
module iic_cfg_seq #(
    parameter logic [7:0]  REG_NUM    = 8'd6,
    parameter logic [19:0] INIT_DELAY = 20'd100,
    parameter logic        VERIFY     = 1'b1,
    parameter logic [1:0]  RETRY_MAX  = 2'd2,
    parameter logic        ADDR16     = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    output logic [7:0]  cfg_index,
    input  logic [23:0] cfg_entry,
    output logic        iic_exe,
    output logic        iic_rw_ctrl,
    output logic        bit_ctrl,
    output logic [15:0] iic_addr,
    output logic [7:0]  iic_data_in,
    input  logic [7:0]  iic_data_out,
    input  logic        iic_ack,
    input  logic        iic_done,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        StWait, StFetch, StWr, StWrWait, StRd, StRdWait, StNext, StFin
    } state_e;

    state_e      state_q, state_d;
    logic [19:0] dly_q, dly_d;
    logic [7:0]  idx_q, idx_d;
    logic [1:0]  retry_q, retry_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        done_q;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        done_rise;
    logic        fail;

    // A done level left high from the previous transaction must not complete the next one.
    assign done_rise = iic_done & ~done_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= StWait;
            dly_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= iic_done;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        fail      = 1'b0;

        case (state_q)
            StWait: begin
                // Widened compare so INIT_DELAY = 0 still leaves after one cycle.
                if ({1'b0, dly_q} + 21'd1 >= {1'b0, INIT_DELAY}) begin
                    dly_d   = '0;
                    state_d = (REG_NUM == 8'd0) ? StFin : StFetch;
                end else begin
                    dly_d = dly_q + 20'd1;
                end
            end
            StFetch: begin
                addr_d  = cfg_entry[23:8];
                wdata_d = cfg_entry[7:0];
                state_d = StWr;
            end
            StWr: state_d = StWrWait;
            StWrWait: begin
                if (done_rise) begin
                    if (iic_ack) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 2'd1;
                            state_d = StWr;
                        end else begin
                            fail    = 1'b1;
                            state_d = StNext;
                        end
                    end else begin
                        state_d = VERIFY ? StRd : StNext;
                    end
                end
            end
            StRd: state_d = StRdWait;
            StRdWait: begin
                if (done_rise) begin
                    if (iic_ack && (retry_q < RETRY_MAX)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = StRd;
                    end else begin
                        fail    = iic_ack || (iic_data_out != wdata_q);
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                retry_d = '0;
                if (idx_q == REG_NUM - 8'd1) begin
                    state_d = StFin;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StFetch;
                end
            end
            StFin: begin
                if (cfg_start) begin
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    idx_d     = '0;
                    dly_d     = '0;
                    state_d   = StWait;
                end
            end
            default: state_d = StWait;
        endcase

        // Every failing path leaves through StNext, so an entry fails at most once.
        if (fail) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    assign cfg_index   = idx_q;
    assign iic_exe     = (state_q == StWr) || (state_q == StRd);
    assign iic_rw_ctrl = !((state_q == StRd) || (state_q == StRdWait));
    assign bit_ctrl    = ADDR16;
    assign iic_addr    = addr_q;
    assign iic_data_in = wdata_q;
    assign cfg_busy    = (state_q != StFin);
    assign cfg_done    = (state_q == StFin);
    assign cfg_err     = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Bench for iic_cfg_seq: two instances (VERIFY = 0 and VERIFY = 1) share clock, reset and
// cfg_start; each has its own behavioural iic_driver that logs every transaction.
module tb_iic_cfg_seq;

    logic clk;
    logic rst;
    logic cfg_start;

    // Fault injection knobs, applied only to the VERIFY = 1 instance.
    int   nack_w0;   // NACK the first nack_w0 writes to 16'h1234
    logic nack_e2;   // always NACK writes to 16'hABCD
    logic bad_e1;    // reads of 16'h0056 return 8'h00

    int n_vec;
    int n_bad;
    int lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0]  cfg_index;
        logic [23:0] cfg_entry;
        logic        iic_exe, iic_rw_ctrl, bit_ctrl;
        logic [15:0] iic_addr;
        logic [7:0]  iic_data_in, iic_data_out;
        logic        iic_ack, iic_done;
        logic        cfg_busy, cfg_done, cfg_err;
        logic [7:0]  err_cnt;

        // Driver model state
        logic        pend;
        logic [1:0]  dly;
        logic        cap_rw;
        logic [15:0] cap_addr;
        logic [7:0]  cap_data;
        int          tx_cnt;
        int          w0_att;
        int          proto_err;
        logic [24:0] log_q [32];
        logic        nack_now;
        logic [7:0]  rdata_now;

        always_comb begin
            case (cfg_index)
                8'd0:    cfg_entry = 24'h1234A5;
                8'd1:    cfg_entry = 24'h00563C;
                8'd2:    cfg_entry = 24'hABCDFF;
                default: cfg_entry = 24'h000000;
            endcase
        end

        iic_cfg_seq #(
            .REG_NUM    (8'd3),
            .INIT_DELAY (20'd10),
            .VERIFY     (g == 1),
            .RETRY_MAX  (2'd2),
            .ADDR16     (1'b1)
        ) u_dut (
            .sys_clk      (clk),
            .sys_rst      (rst),
            .cfg_start    (cfg_start),
            .cfg_index    (cfg_index),
            .cfg_entry    (cfg_entry),
            .iic_exe      (iic_exe),
            .iic_rw_ctrl  (iic_rw_ctrl),
            .bit_ctrl     (bit_ctrl),
            .iic_addr     (iic_addr),
            .iic_data_in  (iic_data_in),
            .iic_data_out (iic_data_out),
            .iic_ack      (iic_ack),
            .iic_done     (iic_done),
            .cfg_busy     (cfg_busy),
            .cfg_done     (cfg_done),
            .cfg_err      (cfg_err),
            .err_cnt      (err_cnt)
        );

        assign nack_now = (g == 1) && cap_rw &&
                          (((cap_addr == 16'h1234) && (w0_att <= nack_w0)) ||
                           ((cap_addr == 16'hABCD) && nack_e2));
        assign rdata_now = ((g == 1) && bad_e1 && (cap_addr == 16'h0056)) ? 8'h00 : cap_data;

        // done drops one cycle after exe and rises three cycles later, then stays high
        // until the next request, so a level-sensitive DUT would see a stale completion.
        always @(posedge clk) begin
            if (rst) begin
                pend         <= 1'b0;
                dly          <= '0;
                iic_done     <= 1'b0;
                iic_ack      <= 1'b0;
                iic_data_out <= '0;
                tx_cnt       <= 0;
                w0_att       <= 0;
            end else if (iic_exe) begin
                if (pend) proto_err <= proto_err + 1;
                pend     <= 1'b1;
                dly      <= '0;
                cap_rw   <= iic_rw_ctrl;
                cap_addr <= iic_addr;
                cap_data <= iic_data_in;
                if (tx_cnt < 32) log_q[tx_cnt] <= {iic_rw_ctrl, iic_addr, iic_data_in};
                tx_cnt   <= tx_cnt + 1;
                if (iic_rw_ctrl && iic_addr == 16'h1234) w0_att <= w0_att + 1;
            end else if (pend) begin
                if (iic_rw_ctrl != cap_rw || iic_addr != cap_addr || iic_data_in != cap_data)
                    proto_err <= proto_err + 1;
                dly <= dly + 2'd1;
                if (dly == 2'd0) iic_done <= 1'b0;
                if (dly == 2'd3) begin
                    iic_done     <= 1'b1;
                    iic_ack      <= nack_now;
                    iic_data_out <= rdata_now;
                    pend         <= 1'b0;
                end
            end
        end

        initial proto_err = 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_idx"},  {24'd0, g_dut[1].cfg_index}, 32'd0);
        check_eq({pfx, "_exe"},  {31'd0, g_dut[1].iic_exe}, 32'd0);
        check_eq({pfx, "_rw"},   {31'd0, g_dut[1].iic_rw_ctrl}, 32'd1);
        check_eq({pfx, "_addr"}, {16'd0, g_dut[1].iic_addr}, 32'd0);
        check_eq({pfx, "_data"}, {24'd0, g_dut[1].iic_data_in}, 32'd0);
        check_eq({pfx, "_stat"}, {28'd0, g_dut[1].cfg_busy, g_dut[1].cfg_done,
                                  g_dut[1].cfg_err, 1'b0}, 32'h8);
        check_eq({pfx, "_cnt"},  {24'd0, g_dut[1].err_cnt}, 32'd0);
    endtask

    // Release reset at a negedge and count cycles to the first exe.
    task automatic release_and_measure(input string tag);
        rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (g_dut[1].iic_exe) begin
                lat = k;
                break;
            end
        end
        check_eq(tag, {31'd0, (lat >= 10 && lat <= 12)}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int ok;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (g_dut[0].cfg_done && g_dut[1].cfg_done) begin
                ok = 1;
                break;
            end
        end
        check_eq(tag, ok, 32'd1);
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        cfg_start = 1'b0;
        nack_w0   = 0;
        nack_e2   = 1'b0;
        bad_e1    = 1'b0;

        // A: reset values, VERIFY=0 writes-only and VERIFY=1 write/read-back, all ACK
        repeat (3) @(negedge clk);
        check_reset("rst");
        check_eq("bit_ctrl", {31'd0, g_dut[1].bit_ctrl}, 32'd1);
        release_and_measure("a_lat");
        wait_done("a_done");
        check_eq("a0_txn", g_dut[0].tx_cnt, 32'd3);
        check_eq("a0_w0", g_dut[0].log_q[0], {7'd0, 1'b1, 24'h1234A5});
        check_eq("a0_w1", g_dut[0].log_q[1], {7'd0, 1'b1, 24'h00563C});
        check_eq("a0_w2", g_dut[0].log_q[2], {7'd0, 1'b1, 24'hABCDFF});
        check_eq("a0_fin", {30'd0, g_dut[0].cfg_done, g_dut[0].cfg_err}, 32'h2);
        check_eq("a0_cnt", {24'd0, g_dut[0].err_cnt}, 32'd0);
        check_eq("a1_txn", g_dut[1].tx_cnt, 32'd6);
        check_eq("a1_w0", g_dut[1].log_q[0], {7'd0, 1'b1, 24'h1234A5});
        check_eq("a1_r0", g_dut[1].log_q[1], {7'd0, 1'b0, 24'h1234A5});
        check_eq("a1_w1", g_dut[1].log_q[2], {7'd0, 1'b1, 24'h00563C});
        check_eq("a1_r1", g_dut[1].log_q[3], {7'd0, 1'b0, 24'h00563C});
        check_eq("a1_w2", g_dut[1].log_q[4], {7'd0, 1'b1, 24'hABCDFF});
        check_eq("a1_r2", g_dut[1].log_q[5], {7'd0, 1'b0, 24'hABCDFF});
        check_eq("a1_err", {31'd0, g_dut[1].cfg_err}, 32'd0);

        // B: read-back mismatch on entry 1
        bad_e1 = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_and_measure("b_lat");
        wait_done("b_done");
        check_eq("b_err", {31'd0, g_dut[1].cfg_err}, 32'd1);
        check_eq("b_cnt", {24'd0, g_dut[1].err_cnt}, 32'd1);
        check_eq("b_txn", g_dut[1].tx_cnt, 32'd6);
        check_eq("b_w2", g_dut[1].log_q[4], {7'd0, 1'b1, 24'hABCDFF});

        // C: entry 0 NACKed twice then ACK; entry 2 always NACKed; cfg_start while busy ignored
        bad_e1  = 1'b0;
        nack_w0 = 2;
        nack_e2 = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_and_measure("c_lat");
        repeat (20) @(negedge clk);
        pulse_start();
        wait_done("c_done");
        check_eq("c_txn", g_dut[1].tx_cnt, 32'd9);
        check_eq("c_w0a", g_dut[1].log_q[0], {7'd0, 1'b1, 24'h1234A5});
        check_eq("c_w0c", g_dut[1].log_q[2], {7'd0, 1'b1, 24'h1234A5});
        check_eq("c_r0", g_dut[1].log_q[3], {7'd0, 1'b0, 24'h1234A5});
        check_eq("c_w2c", g_dut[1].log_q[8], {7'd0, 1'b1, 24'hABCDFF});
        check_eq("c_cnt", {24'd0, g_dut[1].err_cnt}, 32'd1);
        check_eq("c_fin", {30'd0, g_dut[1].cfg_done, g_dut[1].cfg_err}, 32'h3);

        // D: re-run from FIN; entry 0 now ACKs, entry 2 still fails
        pulse_start();
        check_eq("d_stat", {29'd0, g_dut[1].cfg_busy, g_dut[1].cfg_done, g_dut[1].cfg_err},
                 32'h4);
        check_eq("d_clr", {16'd0, g_dut[1].cfg_index, g_dut[1].err_cnt}, 32'd0);
        wait_done("d_done");
        check_eq("d_txn", g_dut[1].tx_cnt, 32'd16);
        check_eq("d_w0", g_dut[1].log_q[9], {7'd0, 1'b1, 24'h1234A5});
        check_eq("d_w2", g_dut[1].log_q[15], {7'd0, 1'b1, 24'hABCDFF});
        check_eq("d_cnt", {24'd0, g_dut[1].err_cnt}, 32'd1);

        // E: reset while the read of entry 1 is outstanding
        nack_w0 = 0;
        nack_e2 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (g_dut[1].tx_cnt == 4) break;
        end
        check_eq("e_rd1", g_dut[1].log_q[3], {7'd0, 1'b0, 24'h00563C});
        rst = 1'b1;
        @(negedge clk);
        check_reset("e_rst");
        @(negedge clk);
        release_and_measure("e_lat");
        wait_done("e_done");
        check_eq("e_w0", g_dut[1].log_q[0], {7'd0, 1'b1, 24'h1234A5});
        check_eq("e_txn", g_dut[1].tx_cnt, 32'd6);
        check_eq("e_err", {31'd0, g_dut[1].cfg_err}, 32'd0);

        check_eq("proto0", g_dut[0].proto_err, 32'd0);
        check_eq("proto1", g_dut[1].proto_err, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
